// File: rtl/vdma_wr_frame_sched_if.sv
// Burst request channel between the write frame scheduler and the AXI write master.
// The scheduler holds the head request (req/addr/len) until the master acks it.
interface vdma_wr_frame_sched_if #(
  parameter int ADDR_W = 32
) ();
  logic              burst_req;
  logic [ADDR_W-1:0] burst_addr;
  logic [8:0]        burst_len;
  logic              burst_ack;

  modport master (output burst_req, burst_addr, burst_len, input burst_ack);
  modport slave  (input burst_req, burst_addr, burst_len, output burst_ack);
endinterface

// File: rtl/vdma_wr_frame_sched.sv
// VDMA write-side frame scheduler: slices the aligned pixel stream into burst requests
// and rotates a ring of frame buffers, skipping the buffer the reader holds.
module vdma_wr_frame_sched #(
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 64,
  parameter int BPB       = 4,
  parameter int BUF_NUM   = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] frame_stride,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic              falign,
  input  logic              lalign,
  input  logic              ealign,
  input  logic              data_vld,
  input  logic [2:0]        rd_buf_idx,
  vdma_wr_frame_sched_if.master bus,
  output logic [2:0]        wr_buf_idx,
  output logic [2:0]        done_buf_idx,
  output logic              frame_done,
  output logic              err_ovf,
  output logic              err_short
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_F, S_ACTIVE, S_FLUSH, S_COMMIT} state_t;

  localparam logic [8:0]        BL       = 9'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BPB_A    = ADDR_W'(BPB);
  localparam logic [2:0]        LAST_IDX = 3'(BUF_NUM - 1);

  function automatic logic [2:0] ring_inc(input logic [2:0] idx);
    return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

  state_t            state_q, state_d;
  logic [8:0]        pcnt_q, pcnt_d;
  logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] buf_off_q, buf_off_d;
  logic [ADDR_W-1:0] fstride_q, fstride_d;
  logic [ADDR_W-1:0] lstride_q, lstride_d;
  logic [ADDR_W-1:0] q_addr_q [2];
  logic [ADDR_W-1:0] q_addr_d [2];
  logic [8:0]        q_len_q [2];
  logic [8:0]        q_len_d [2];
  logic [1:0]        q_cnt_q, q_cnt_d;
  logic [2:0]        wr_q, wr_d, done_q, done_d;
  logic              frame_done_q, frame_done_d;
  logic              ovf_q, ovf_d, short_q, short_d;

  logic              push, pop;
  logic [8:0]        push_len, pc_inc;
  logic [ADDR_W-1:0] push_addr, off1, off2;
  logic [2:0]        i1, i2;
  logic [1:0]        cnt_mid;

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    frame_addr_d = frame_addr_q;
    line_addr_d  = line_addr_q;
    offset_d     = offset_q;
    buf_off_d    = buf_off_q;
    fstride_d    = fstride_q;
    lstride_d    = lstride_q;
    q_addr_d     = q_addr_q;
    q_len_d      = q_len_q;
    wr_d         = wr_q;
    done_d       = done_q;
    frame_done_d = 1'b0;
    ovf_d        = 1'b0;
    short_d      = 1'b0;
    push         = 1'b0;
    push_len     = '0;
    push_addr    = line_addr_q + offset_q;
    pc_inc       = pcnt_q + {8'd0, data_vld};
    i1           = ring_inc(wr_q);
    i2           = ring_inc(i1);
    off1         = (i1 == 3'd0) ? '0 : buf_off_q + fstride_q;
    off2         = (i2 == 3'd0) ? '0 : off1 + fstride_q;

    case (state_q)
      S_IDLE: if (enable) state_d = S_WAIT_F;
      S_WAIT_F: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (falign) begin
          fstride_d    = frame_stride;
          lstride_d    = line_stride;
          frame_addr_d = frame_base + buf_off_q;
          line_addr_d  = frame_base + buf_off_q;
          offset_d     = '0;
          pcnt_d       = {8'd0, data_vld};
          state_d      = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A premature frame start discards the partial burst and rewrites the same buffer.
        if (falign) begin
          short_d     = 1'b1;
          line_addr_d = frame_addr_q;
          offset_d    = '0;
          pcnt_d      = {8'd0, data_vld};
        end else begin
          if (pc_inc == BL || (lalign && pc_inc != '0)) begin
            push     = 1'b1;
            push_len = pc_inc;
            pcnt_d   = '0;
            offset_d = offset_q + ADDR_W'(pc_inc) * BPB_A;
          end else begin
            pcnt_d = pc_inc;
          end
          if (lalign) begin
            line_addr_d = line_addr_q + lstride_q;
            offset_d    = '0;
          end
          if (ealign) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (pcnt_q != '0) begin
          push     = 1'b1;
          push_len = pcnt_q;
          offset_d = offset_q + ADDR_W'(pcnt_q) * BPB_A;
        end
        pcnt_d  = '0;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        // Commit only after every burst of the frame has been handed to the master.
        if (q_cnt_q == 2'd0) begin
          done_d       = wr_q;
          frame_done_d = 1'b1;
          if (i1 == rd_buf_idx) begin
            wr_d      = i2;
            buf_off_d = off2;
          end else begin
            wr_d      = i1;
            buf_off_d = off1;
          end
          state_d = enable ? S_WAIT_F : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pop     = bus.burst_ack && (q_cnt_q != 2'd0);
    cnt_mid = q_cnt_q - {1'b0, pop};
    if (pop) begin
      q_addr_d[0] = q_addr_q[1];
      q_len_d[0]  = q_len_q[1];
    end
    if (push) begin
      if (cnt_mid == 2'd2) begin
        ovf_d = 1'b1;
      end else begin
        if (cnt_mid == 2'd0) begin
          q_addr_d[0] = push_addr;
          q_len_d[0]  = push_len;
        end else begin
          q_addr_d[1] = push_addr;
          q_len_d[1]  = push_len;
        end
        cnt_mid = cnt_mid + 2'd1;
      end
    end
    q_cnt_d = cnt_mid;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pcnt_q       <= '0;
      frame_addr_q <= '0;
      line_addr_q  <= '0;
      offset_q     <= '0;
      buf_off_q    <= '0;
      fstride_q    <= '0;
      lstride_q    <= '0;
      q_addr_q[0]  <= '0;
      q_addr_q[1]  <= '0;
      q_len_q[0]   <= '0;
      q_len_q[1]   <= '0;
      q_cnt_q      <= '0;
      wr_q         <= '0;
      done_q       <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      frame_addr_q <= frame_addr_d;
      line_addr_q  <= line_addr_d;
      offset_q     <= offset_d;
      buf_off_q    <= buf_off_d;
      fstride_q    <= fstride_d;
      lstride_q    <= lstride_d;
      q_addr_q     <= q_addr_d;
      q_len_q      <= q_len_d;
      q_cnt_q      <= q_cnt_d;
      wr_q         <= wr_d;
      done_q       <= done_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      short_q      <= short_d;
    end
  end

  assign bus.burst_req  = (q_cnt_q != 2'd0);
  assign bus.burst_addr = q_addr_q[0];
  assign bus.burst_len  = q_len_q[0];
  assign wr_buf_idx     = wr_q;
  assign done_buf_idx   = done_q;
  assign frame_done     = frame_done_q;
  assign err_ovf        = ovf_q;
  assign err_short      = short_q;

endmodule

// File: tb/tb_vdma_wr_frame_sched.sv
// Randomized scoreboard bench for vdma_wr_frame_sched: a frame-level model predicts every
// burst and committed buffer, and a monitor checks them as the DUT presents them.
module tb_vdma_wr_frame_sched;
  localparam int ADDR_W = 32;
  localparam int BL     = 64;
  localparam int BPB    = 4;
  localparam int NBUF   = 3;
  localparam logic [31:0] BASE = 32'h1000;
  localparam logic [31:0] LSTR = 32'h200;
  localparam logic [31:0] FSTR = 32'h10000;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        falign = 1'b0, lalign = 1'b0, ealign = 1'b0, data_vld = 1'b0;
  logic [31:0] frame_base = BASE, frame_stride = FSTR, line_stride = LSTR;
  logic [2:0]  rd_buf_idx = 3'd0;
  logic [2:0]  wr_buf_idx, done_buf_idx;
  logic        frame_done, err_ovf, err_short;

  vdma_wr_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

  vdma_wr_frame_sched #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .BPB(BPB), .BUF_NUM(NBUF)) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable),
    .frame_base(frame_base), .frame_stride(frame_stride), .line_stride(line_stride),
    .falign(falign), .lalign(lalign), .ealign(ealign), .data_vld(data_vld),
    .rd_buf_idx(rd_buf_idx), .bus(bus),
    .wr_buf_idx(wr_buf_idx), .done_buf_idx(done_buf_idx),
    .frame_done(frame_done), .err_ovf(err_ovf), .err_short(err_short)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a;
    logic [8:0]  l;
  } burst_t;

  burst_t sb[$];
  int     done_q[$];
  int     total = 0, bad = 0;
  int     ovf_seen = 0, short_seen = 0, done_seen = 0;
  int     exp_ovf = 0, exp_short = 0;
  int     ack_mode = 0;   // 0: always ack, 1: random ack, 2: hold ack low
  int     wr_m = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each line is a run of pixels cut into BURST_LEN chunks at consecutive addresses.
  function automatic void emit(input logic [31:0] la, input int n);
    int l;
    logic [31:0] a;
    a = la;
    while (n > 0) begin
      l = (n > BL) ? BL : n;
      sb.push_back('{a: a, l: 9'(l)});
      a = a + 32'(l * BPB);
      n = n - l;
    end
  endfunction

  function automatic int next_buf(input int w, input int rd);
    int n;
    n = (w + 1) % NBUF;
    if (n == rd) n = (w + 2) % NBUF;
    return n;
  endfunction

  always begin
    @(posedge clock);
    #1;
    case (ack_mode)
      0:       bus.burst_ack = 1'b1;
      1:       bus.burst_ack = ($urandom_range(3) != 0);
      default: bus.burst_ack = 1'b0;
    endcase
  end

  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.burst_req) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL burst_unexpected: got addr %0h len %0d expected no request", bus.burst_addr, bus.burst_len);
        end else begin
          chk("burst_addr", bus.burst_addr, sb[0].a);
          chk("burst_len", bus.burst_len, sb[0].l);
          if (bus.burst_ack) void'(sb.pop_front());
        end
      end
      if (err_ovf) ovf_seen++;
      if (err_short) short_seen++;
      if (frame_done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_done_unexpected: got done_buf %0d expected no commit", done_buf_idx);
        end else begin
          chk("done_buf_idx", done_buf_idx, done_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send_line(input int n, input bit lal, input bit eal);
    bit same;
    same = eal ? 1'b1 : 1'($urandom_range(1));
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(3) == 0) cyc();
      data_vld = 1'b1;
      if (i == n - 1) begin
        if (lal && same) lalign = 1'b1;
        if (eal) ealign = 1'b1;
      end
      cyc();
      data_vld = 1'b0;
      lalign   = 1'b0;
      ealign   = 1'b0;
    end
    if (lal && !same) begin
      lalign = 1'b1;
      cyc();
      lalign = 1'b0;
    end
  endtask

  task automatic pulse_falign();
    cyc();
    falign = 1'b1;
    cyc();
    falign = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int k;
    k = 0;
    while (done_seen == prev && k < 3000) begin
      cyc();
      k++;
    end
    if (done_seen == prev) begin
      total++;
      bad++;
      $display("FAIL frame_done_timeout: got no pulse expected one within 3000 cycles");
    end
  endtask

  task automatic run_frame(input int nl, input int hact, input bit whole, input int rd,
                           input bit do_short, input bit scramble);
    logic [31:0] fa;
    int          prev;
    bit          eal_last;
    rd_buf_idx = 3'(rd);
    fa   = BASE + 32'(wr_m) * FSTR;
    prev = done_seen;
    if (do_short) begin
      sb.push_back('{a: fa, l: 9'(BL)});
      pulse_falign();
      send_line(70, 1'b0, 1'b0);
      exp_short++;
    end
    if (whole) emit(fa, nl * hact);
    else for (int l = 0; l < nl; l++) emit(fa + 32'(l) * LSTR, hact);
    done_q.push_back(wr_m);
    pulse_falign();
    if (do_short) begin
      cyc();
      chk("err_short_count", short_seen, exp_short);
      chk("wr_buf_after_short", wr_buf_idx, wr_m);
      chk("no_done_after_short", done_seen, prev);
    end
    if (scramble) begin
      frame_base   = $urandom;
      frame_stride = $urandom;
      line_stride  = $urandom;
    end
    eal_last = 1'($urandom_range(1));
    for (int l = 0; l < nl; l++) send_line(hact, !whole, eal_last && (l == nl - 1));
    if (!eal_last) begin
      cyc();
      ealign = 1'b1;
      cyc();
      ealign = 1'b0;
    end
    frame_base   = BASE;
    frame_stride = FSTR;
    line_stride  = LSTR;
    wait_done(prev);
    wr_m = next_buf(wr_m, rd);
    chk("wr_buf_idx", wr_buf_idx, wr_m);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fa;
    int          prev;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_burst_req", bus.burst_req, 0);
    chk("rst_burst_addr", bus.burst_addr, 0);
    chk("rst_burst_len", bus.burst_len, 0);
    chk("rst_wr_buf", wr_buf_idx, 0);
    chk("rst_done_buf", done_buf_idx, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_err_short", err_short, 0);
    cyc();
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) cyc();

    ack_mode = 0;
    run_frame(2, 128, 1'b0, 2, 1'b0, 1'b0);   // buf0: 0x1000..0x1300 len 64
    ack_mode = 1;
    run_frame(2, 100, 1'b0, 2, 1'b0, 1'b1);   // 64 + 36 per line, buf1 -> skip 2 -> 0
    run_frame(1, 64, 1'b0, 1, 1'b0, 1'b0);    // rd=1 on buf0 -> 2
    run_frame(1, 64, 1'b0, 1, 1'b0, 1'b0);    // 2 -> 0
    run_frame(4, 64, 1'b1, 2, 1'b0, 1'b0);    // whole frame 256 px on buf0 -> 1
    run_frame(1, 100, 1'b0, 0, 1'b1, 1'b0);   // short frame, restart on buf1 -> 2

    // Three bursts with ack held low: two queue, the third is dropped.
    ack_mode   = 2;
    rd_buf_idx = 3'd1;
    fa   = BASE + 32'(wr_m) * FSTR;
    prev = done_seen;
    sb.push_back('{a: fa, l: 9'(BL)});
    sb.push_back('{a: fa + 32'h100, l: 9'(BL)});
    done_q.push_back(wr_m);
    exp_ovf++;
    pulse_falign();
    send_line(192, 1'b0, 1'b0);
    ealign = 1'b1;
    cyc();
    ealign = 1'b0;
    repeat (10) cyc();
    chk("err_ovf_count", ovf_seen, exp_ovf);
    chk("commit_waits_queue", done_seen, prev);
    chk("req_held", bus.burst_req, 1);
    ack_mode = 1;
    wait_done(prev);
    wr_m = next_buf(wr_m, 1);
    chk("wr_buf_after_ovf", wr_buf_idx, wr_m);

    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(1, 3), $urandom_range(20, 200), 1'($urandom_range(1)),
                $urandom_range(0, 2), 1'b0, 1'b1);
    end

    // Reset in the middle of a frame with a request pending.
    ack_mode   = 2;
    rd_buf_idx = 3'd2;
    fa = BASE + 32'(wr_m) * FSTR;
    sb.push_back('{a: fa, l: 9'(BL)});
    pulse_falign();
    send_line(70, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_burst_req", bus.burst_req, 0);
    chk("midrst_wr_buf", wr_buf_idx, 0);
    chk("midrst_done_buf", done_buf_idx, 0);
    repeat (2) cyc();
    rst_n    = 1'b1;
    wr_m     = 0;
    ack_mode = 1;
    repeat (3) cyc();
    run_frame(1, 80, 1'b0, 2, 1'b0, 1'b0);

    repeat (5) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    chk("commits_drained", done_q.size(), 0);
    chk("err_ovf_total", ovf_seen, exp_ovf);
    chk("err_short_total", short_seen, exp_short);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
